// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_pkg
// Purpose  : Shared encodings for the machine-mode CSR access sequencer:
//            op codes, implemented CSR addresses, FSM states, trap causes.
// Revision : 1.0  initial release
// ============================================================================
package csr_pkg;

  // EXU op encodings
  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  // Implemented machine-mode CSRs
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_TRAP  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Trap cause codes
  localparam int CAUSE_ECALL_M = 11;

  typedef logic [2:0] op_t;

  // True for the three read-modify-write CSR instructions
  function automatic logic op_is_csr(input op_t op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  // True for addresses that exist in the CSR file
  function automatic logic csr_implemented(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_rmw_alu.sv
`default_nettype none
// ============================================================================
// Module   : csr_rmw_alu
// Purpose  : Combinational new-value computation for CSRRW/CSRRS/CSRRC and
//            the write-suppress flag for set/clear with a zero mask.
// Revision : 1.0  initial release
// ============================================================================
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src_val,
  output logic [XLEN-1:0] new_val,
  output logic            wr_suppress
);

  // Set/clear with an all-zero mask must not touch the CSR at all
  always_comb begin
    new_val     = src_val;
    wr_suppress = 1'b0;
    case (op)
      OP_CSRRS: begin
        new_val     = old_val | src_val;
        wr_suppress = (src_val == '0);
      end
      OP_CSRRC: begin
        new_val     = old_val & ~src_val;
        wr_suppress = (src_val == '0);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_seq_ctrl
// Purpose  : Multi-cycle sequencer owning the single CSR-file access port.
//            CSR ops run read-then-write, ECALL raises a trap, MRET returns
//            to mepc. Results go back to EXU over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module csr_seq_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_src,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_npc,
  output logic            resp_illegal,
  output logic [XLEN-1:0] csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_wen,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            exc,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc
);

  logic [2:0]      state_q,   state_d;
  logic [2:0]      op_q,      op_d;
  logic [11:0]     csr_q,     csr_d;
  logic [XLEN-1:0] src_q,     src_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] old_q,     old_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_new;
  logic            alu_suppress;
  logic [XLEN-1:0] csr_addr_ext;

  assign csr_addr_ext = {{(XLEN-12){1'b0}}, csr_q};

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op          (op_q),
    .old_val     (old_q),
    .src_val     (src_q),
    .new_val     (alu_new),
    .wr_suppress (alu_suppress)
  );

  // Sequencer next state and operand capture
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    csr_d     = csr_q;
    src_d     = src_q;
    pc_d      = pc_q;
    old_d     = old_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          csr_d     = req_csr;
          src_d     = req_src;
          pc_d      = req_pc;
          old_d     = '0;
          illegal_d = 1'b0;
          if (op_is_csr(req_op)) begin
            state_d = ST_READ;
          end else if (req_op == OP_ECALL) begin
            state_d = ST_TRAP;
          end else begin
            state_d   = ST_RESP;
            illegal_d = (req_op != OP_MRET);
          end
        end
      end
      ST_READ: begin
        // Unimplemented addresses skip the write and return zero
        if (csr_implemented(csr_q)) begin
          old_d   = csr_rdata;
          state_d = ST_WRITE;
        end else begin
          old_d     = '0;
          illegal_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_TRAP:  state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand registers; reset drops any pending op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      csr_q     <= '0;
      src_q     <= '0;
      pc_q      <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      csr_q     <= csr_d;
      src_q     <= src_d;
      pc_q      <= pc_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode; side effects are masked during reset so a reset in
  // WRITE or TRAP never reaches the CSR file
  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    csr_addr      = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? csr_addr_ext : '0;
    csr_wen       = (state_q == ST_WRITE) && !alu_suppress && !rst;
    csr_wdata     = (state_q == ST_WRITE) ? alu_new : '0;
    exc           = (state_q == ST_TRAP) && !rst;
    exc_pc        = (state_q == ST_TRAP) ? pc_q : '0;
    exc_cause     = (state_q == ST_TRAP) ? XLEN'(ECALL_CAUSE) : '0;
    resp_valid    = (state_q == ST_RESP);
    resp_rdata    = (state_q == ST_RESP) ? old_q : '0;
    resp_illegal  = (state_q == ST_RESP) && illegal_q;
    resp_redirect = (state_q == ST_RESP) && ((op_q == OP_ECALL) || (op_q == OP_MRET));
    resp_npc      = '0;
    if (state_q == ST_RESP) begin
      if (op_q == OP_ECALL)     resp_npc = mtvec;
      else if (op_q == OP_MRET) resp_npc = mepc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_seq_ctrl
// Purpose  : Self-checking bench for csr_seq_ctrl with a behavioural CSR
//            file, a transaction-level reference model and a per-cycle
//            compare process, plus literal directed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_src = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_npc;
  logic        resp_illegal;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        exc;
  logic [31:0] exc_pc;
  logic [31:0] exc_cause;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  csr_seq_ctrl #(.XLEN(32), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_src(req_src), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_npc(resp_npc), .resp_illegal(resp_illegal),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_rdata(csr_rdata),
    .exc(exc), .exc_pc(exc_pc), .exc_cause(exc_cause),
    .mtvec(mtvec), .mepc(mepc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural CSR file ----------------
  logic [31:0] f_mstatus = 32'h0000_1800;
  logic [31:0] f_mtvec   = 32'h0;
  logic [31:0] f_mepc    = 32'h0;
  logic [31:0] f_mcause  = 32'h0;
  int wen_cnt = 0;
  int exc_cnt = 0;

  assign mtvec = f_mtvec;
  assign mepc  = f_mepc;

  always_comb begin
    case (csr_addr)
      32'h300: csr_rdata = f_mstatus;
      32'h305: csr_rdata = f_mtvec;
      32'h341: csr_rdata = f_mepc;
      32'h342: csr_rdata = f_mcause;
      default: csr_rdata = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen) begin
      wen_cnt <= wen_cnt + 1;
      case (csr_addr)
        32'h300: f_mstatus <= csr_wdata;
        32'h305: f_mtvec   <= csr_wdata;
        32'h341: f_mepc    <= csr_wdata;
        32'h342: f_mcause  <= csr_wdata;
        default: ;
      endcase
    end
    if (exc) begin
      exc_cnt  <= exc_cnt + 1;
      f_mepc   <= exc_pc;
      f_mcause <= exc_cause;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_csr [4] = '{32'h0000_1800, 32'h0, 32'h0, 32'h0};

  function automatic int idx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  // Expectations for the transaction in flight
  bit          in_txn = 1'b0;
  int          acc = 0;
  int          e_lat = 1;
  bit          e_wen, e_exc, e_access, e_redirect, e_illegal;
  logic [31:0] e_addr, e_wdata, e_rdata, e_npc, e_pc;

  // Observed response, captured by the driver
  logic [31:0] got_rdata, got_npc;
  logic        got_redirect, got_illegal;
  int          got_lat;

  // Per-cycle comparison against the model's view of the transaction
  always @(negedge clk) begin
    int n;
    n = cyc - acc + 1;
    if (rst) begin
      chk("rst_no_wen", csr_wen, 0);
      chk("rst_no_exc", exc, 0);
    end else if (!in_txn || n <= 0) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_wen", csr_wen, 0);
      chk("idle_exc", exc, 0);
      chk("idle_redirect", resp_redirect, 0);
      chk("idle_illegal", resp_illegal, 0);
      chk("idle_rdata", resp_rdata, 0);
    end else begin
      chk("busy_req_ready", req_ready, 0);
      chk("resp_valid", resp_valid, 32'(n >= e_lat));
      chk("csr_wen", csr_wen, 32'(e_wen && n == e_lat - 1));
      chk("exc", exc, 32'(e_exc && n == e_lat - 1));
      if (e_access && n <= e_lat - 1) chk("csr_addr", csr_addr, e_addr);
      if (e_wen && n == e_lat - 1) chk("csr_wdata", csr_wdata, e_wdata);
      if (e_exc && n == e_lat - 1) begin
        chk("exc_pc", exc_pc, e_pc);
        chk("exc_cause", exc_cause, 32'd11);
      end
      if (n >= e_lat) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_redirect", resp_redirect, 32'(e_redirect));
        chk("resp_illegal", resp_illegal, 32'(e_illegal));
        if (e_redirect) chk("resp_npc", resp_npc, e_npc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transaction; optionally assert reset in the WRITE cycle
  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                       input logic [31:0] pc, input int hold, input bit rst_in_write);
    int i;
    int waited;
    logic [31:0] nv;
    i = idx(a);
    e_wen = 0; e_exc = 0; e_access = 0; e_redirect = 0; e_illegal = 0;
    e_rdata = 0; e_npc = 0; e_wdata = 0; e_pc = pc; e_addr = {20'h0, a};
    if (op <= 3'd2) begin
      e_access = 1;
      if (i < 0) begin
        e_lat = 2;
        e_illegal = 1;
      end else begin
        e_lat = 3;
        e_rdata = m_csr[i];
        nv = (op == 3'd0) ? src : (op == 3'd1) ? (m_csr[i] | src) : (m_csr[i] & ~src);
        e_wen = (op == 3'd0) || (src != 0);
        e_wdata = nv;
        if (e_wen && !rst_in_write) m_csr[i] = nv;
      end
    end else if (op == 3'd3) begin
      e_lat = 2;
      e_exc = 1;
      e_redirect = 1;
      e_npc = m_csr[1];
      m_csr[2] = pc;
      m_csr[3] = 32'd11;
    end else if (op == 3'd4) begin
      e_lat = 1;
      e_redirect = 1;
      e_npc = m_csr[2];
    end else begin
      e_lat = 1;
      e_illegal = 1;
    end

    req_valid = 1; req_op = op; req_csr = a; req_src = src; req_pc = pc;
    acc = cyc + 1;
    in_txn = 1;
    tick();
    req_valid = 0;
    req_op = 3'($urandom); req_csr = 12'($urandom); req_src = $urandom; req_pc = $urandom;

    if (rst_in_write) begin
      tick();
      rst = 1;
      tick();
      rst = 0;
      in_txn = 0;
      return;
    end

    waited = 0;
    while (!resp_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", resp_valid, 1);
      rst = 1;
      tick();
      rst = 0;
      in_txn = 0;
      return;
    end
    got_lat = waited + 1;
    got_rdata = resp_rdata;
    got_npc = resp_npc;
    got_redirect = resp_redirect;
    got_illegal = resp_illegal;
    repeat (hold) tick();
    resp_ready = 1;
    tick();
    resp_ready = 0;
    in_txn = 0;

    chk("file_mstatus", f_mstatus, m_csr[0]);
    chk("file_mtvec", f_mtvec, m_csr[1]);
    chk("file_mepc", f_mepc, m_csr[2]);
    chk("file_mcause", f_mcause, m_csr[3]);
  endtask

  initial begin
    int w0, x0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);

    // CSRRW mtvec
    w0 = wen_cnt;
    issue(3'd0, 12'h305, 32'h8000_0100, 32'h8000_0000, 0, 0);
    chk("rw_lat", 32'(got_lat), 32'd3);
    chk("rw_rdata", got_rdata, 32'h0);
    chk("rw_mtvec", f_mtvec, 32'h8000_0100);
    chk("rw_wen_pulses", 32'(wen_cnt - w0), 32'd1);

    // CSRRS mstatus, then zero mask
    issue(3'd1, 12'h300, 32'h8, 32'h8000_0004, 1, 0);
    chk("rs_rdata", got_rdata, 32'h1800);
    chk("rs_mstatus", f_mstatus, 32'h1808);
    w0 = wen_cnt;
    issue(3'd1, 12'h300, 32'h0, 32'h8000_0008, 0, 0);
    chk("rs0_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    chk("rs0_rdata", got_rdata, 32'h1808);

    // ECALL then MRET
    x0 = exc_cnt;
    issue(3'd3, 12'h000, 32'h0, 32'h8000_0040, 2, 0);
    chk("ecall_lat", 32'(got_lat), 32'd2);
    chk("ecall_exc_pulses", 32'(exc_cnt - x0), 32'd1);
    chk("ecall_mepc", f_mepc, 32'h8000_0040);
    chk("ecall_mcause", f_mcause, 32'd11);
    chk("ecall_npc", got_npc, 32'h8000_0100);
    chk("ecall_redirect", 32'(got_redirect), 32'd1);
    issue(3'd4, 12'h000, 32'h0, 32'h8000_0200, 0, 0);
    chk("mret_lat", 32'(got_lat), 32'd1);
    chk("mret_redirect", 32'(got_redirect), 32'd1);
    chk("mret_npc", got_npc, 32'h8000_0040);

    // Illegal CSR and reserved op
    w0 = wen_cnt;
    issue(3'd0, 12'h7C0, 32'h1234_5678, 32'h8000_0300, 0, 0);
    chk("badcsr_illegal", 32'(got_illegal), 32'd1);
    chk("badcsr_rdata", got_rdata, 32'h0);
    chk("badcsr_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    issue(3'd6, 12'h300, 32'h0, 32'h8000_0304, 0, 0);
    chk("resv_illegal", 32'(got_illegal), 32'd1);
    chk("resv_lat", 32'(got_lat), 32'd1);

    // Back-pressure and reset in WRITE
    issue(3'd2, 12'h300, 32'h800, 32'h8000_0400, 5, 0);
    chk("rc_rdata", got_rdata, 32'h1808);
    w0 = wen_cnt;
    issue(3'd0, 12'h305, 32'h0000_1234, 32'h8000_0500, 0, 1);
    chk("rstw_wen_pulses", 32'(wen_cnt - w0), 32'd0);
    chk("rstw_mtvec", f_mtvec, 32'h8000_0100);
    chk("rstw_idle", req_ready, 1);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      int r;
      logic [2:0]  op;
      logic [11:0] a;
      logic [31:0] src;
      r = $urandom_range(0, 9);
      if (r < 6)       op = 3'(r % 3);
      else if (r == 6) op = 3'd3;
      else if (r == 7) op = 3'd4;
      else if (r == 8) op = 3'(5 + $urandom_range(0, 2));
      else             op = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0: a = 12'h300;
        1: a = 12'h305;
        2: a = 12'h341;
        3: a = 12'h342;
        default: a = 12'($urandom);
      endcase
      src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      issue(op, a, src, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), 0);
      repeat ($urandom_range(0, 1)) tick();
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
